// File: rtl/countdown_mmss.sv
// countdown_mmss: BCD MM:SS countdown timer.
// Loads a packed-BCD preset, counts down once per 1 Hz tick enable while
// running, pulses BO when seconds wrap 00->59, and holds alarm high in DONE
// for ALARM_TICKS ticks before returning to IDLE. All outputs are registered.
module countdown_mmss #(
   parameter int ALARM_TICKS = 10
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       tick,
   input  logic       load,
   input  logic [7:0] set_min,
   input  logic [7:0] set_sec,
   input  logic       start,
   input  logic       stop,
   output logic [7:0] min,
   output logic [7:0] sec,
   output logic       running,
   output logic       BO,
   output logic       alarm,
   output logic       err
);

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      RUN   = 2'd1,
      PAUSE = 2'd2,
      DONE  = 2'd3
   } state_t;

   // Terminal value of the alarm tick counter (counter runs 0..ALARM_TICKS-1).
   localparam logic [7:0] ALARM_LAST = 8'(ALARM_TICKS - 1);

   state_t     state;
   logic [7:0] alarm_cnt;

   logic       preset_ok;
   logic       value_zero;
   logic       sec_zero;
   logic [7:0] sec_nxt;
   logic [7:0] min_nxt;
   logic       nxt_zero;

   // A packed-BCD 00..59 field: units nibble 0..9, tens nibble 0..5.
   function automatic logic bcd_ok(input logic [7:0] v);
      return (v[7:4] <= 4'd5) && (v[3:0] <= 4'd9);
   endfunction

   // One-step BCD decrement of a two-digit field; caller guarantees v != 00.
   function automatic logic [7:0] bcd_dec(input logic [7:0] v);
      logic [7:0] r;
      if (v[3:0] == 4'd0) begin
         r = {v[7:4] - 4'd1, 4'd9};
      end else begin
         r = {v[7:4], v[3:0] - 4'd1};
      end
      return r;
   endfunction

   // Decode of the preset and of the value one second below the current one.
   always_comb begin
      preset_ok  = bcd_ok(set_min) && bcd_ok(set_sec);
      value_zero = (min == 8'h00) && (sec == 8'h00);
      sec_zero   = (sec == 8'h00);
      sec_nxt    = sec_zero ? 8'h59 : bcd_dec(sec);
      min_nxt    = sec_zero ? bcd_dec(min) : min;
      nxt_zero   = (min_nxt == 8'h00) && (sec_nxt == 8'h00);
   end

   // Timer state machine: command priority load > stop > start > tick.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state     <= IDLE;
         min       <= 8'h00;
         sec       <= 8'h00;
         running   <= 1'b0;
         BO        <= 1'b0;
         alarm     <= 1'b0;
         err       <= 1'b0;
         alarm_cnt <= 8'd0;
      end else begin
         BO  <= 1'b0;
         err <= 1'b0;
         if (load) begin
            if (preset_ok) begin
               min       <= set_min;
               sec       <= set_sec;
               state     <= IDLE;
               running   <= 1'b0;
               alarm     <= 1'b0;
               alarm_cnt <= 8'd0;
            end else begin
               err <= 1'b1;
            end
         end else if (stop) begin
            if (state == RUN) begin
               state   <= PAUSE;
               running <= 1'b0;
            end
         end else if (start) begin
            if (state == IDLE || state == PAUSE) begin
               if (value_zero) begin
                  // Nothing to count: alarm immediately.
                  state     <= DONE;
                  running   <= 1'b0;
                  alarm     <= 1'b1;
                  alarm_cnt <= 8'd0;
               end else begin
                  state   <= RUN;
                  running <= 1'b1;
               end
            end
         end else if (tick) begin
            case (state)
               RUN: begin
                  min <= min_nxt;
                  sec <= sec_nxt;
                  BO  <= sec_zero;
                  if (nxt_zero) begin
                     state     <= DONE;
                     running   <= 1'b0;
                     alarm     <= 1'b1;
                     alarm_cnt <= 8'd0;
                  end
               end
               DONE: begin
                  if (alarm_cnt == ALARM_LAST) begin
                     state     <= IDLE;
                     alarm     <= 1'b0;
                     alarm_cnt <= 8'd0;
                  end else begin
                     alarm_cnt <= alarm_cnt + 8'd1;
                  end
               end
               default: begin
                  // IDLE and PAUSE ignore ticks.
               end
            endcase
         end
      end
   end

endmodule
